led_fade_pwm_driver: RTL and testbench

//  Downstream stage of the LED pattern generator. Consumes its 8-bit on/off pattern and drives the pins.

---
 rtl/led_pkg.sv | 23 ++
 rtl/led_fade_pwm_driver_if.sv | 29 ++
 rtl/led_pwm_channel.sv | 71 +++++++
 rtl/led_fade_pwm_driver.sv | 86 ++++++++
 tb/tb_led_fade_pwm_driver.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared LED dimming definitions: level width, full-scale value and the gamma curve.
// The gamma curve only affects the build when LED_FADE_GAMMA_EN is defined.
package led_pkg;

  localparam int LED_PWM_BITS  = 8;
  localparam int LED_MAX_LEVEL = (1 << LED_PWM_BITS) - 1;

  typedef logic [LED_PWM_BITS-1:0] led_level_t;

  // Square-law perceptual curve for any level width up to 16 bits.
  // Full scale maps to full scale so a solid-on LED stays solidly on.
  function automatic logic [15:0] led_gamma(input logic [15:0] lvl, input int unsigned bits);
    logic [31:0] sq;
    logic [15:0] lvl_max;
    lvl_max = 16'((32'd1 << bits) - 32'd1);
    sq      = {16'd0, lvl} * {16'd0, lvl};
    if (lvl == lvl_max) begin
      return lvl_max;
    end
    return 16'(sq >> bits);
  endfunction

endpackage

// File: rtl/led_fade_pwm_driver_if.sv
// Pattern-in / pins-out bundle of the LED fade driver.
// master = pattern generator side, slave = the driver itself.
interface led_fade_pwm_driver_if #(
  parameter int NUM_LEDS = 8
);

  logic                ena;
  logic [NUM_LEDS-1:0] pattern_in;
  logic [NUM_LEDS-1:0] led_out;
  logic                frame_start;
  logic                fading;

  modport master (
    output ena,
    output pattern_in,
    input  led_out,
    input  frame_start,
    input  fading
  );

  modport slave (
    input  ena,
    input  pattern_in,
    output led_out,
    output frame_start,
    output fading
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: afterglow level, period-latched duty and registered PWM compare.
// Duty shaping is the gamma curve when LED_FADE_GAMMA_EN is defined, linear otherwise.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_STEP = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                tick,
  input  logic                period_end,
  input  logic                pattern_bit,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_o,
  output logic                fade_nxt_o
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] level_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic [PWM_BITS-1:0] shaped;
  logic                led_q;
  logic                led_d;

`ifdef LED_FADE_GAMMA_EN
  assign shaped = PWM_BITS'(led_gamma(16'(level_q), PWM_BITS));
`else
  assign shaped = level_q;
`endif

  always_comb begin
    level_d = level_q;
    duty_d  = duty_q;
    led_d   = led_q;
    if (ena) begin
      // A set always beats a coincident decay tick; decay saturates at zero.
      if (pattern_bit) begin
        level_d = LVL_MAX;
      end else if (tick) begin
        level_d = (level_q > STEP) ? level_q - STEP : '0;
      end
      if (period_end) begin
        duty_d = shaped;
      end
      led_d = (duty_q > pwm_cnt);
    end
  end

  // Next-state view so the registered fading flag lines up with the level register.
  assign fade_nxt_o = (level_d != '0) && !pattern_bit;
  assign led_o      = led_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      duty_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_fade_pwm_driver.sv
// LED afterglow PWM driver: shared decay prescaler, PWM period counter, per-channel fade/PWM.
// Optional gamma-shaped duty via LED_FADE_GAMMA_EN; default build is linear.
module led_fade_pwm_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_DIV  = 16,
  parameter int DECAY_STEP = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  led_fade_pwm_driver_if.slave  bus
);

  localparam int                  PRE_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_MAX - 1'b1;

  logic [PRE_W-1:0]    presc_q;
  logic [PRE_W-1:0]    presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic                frame_start_q;
  logic                frame_start_d;
  logic                fading_q;
  logic                fading_d;
  logic                tick;
  logic                period_end;
  logic [NUM_LEDS-1:0] fade_nxt;
  logic [NUM_LEDS-1:0] led_bits;

  // Channels gate these with ena themselves, so a frozen cycle never consumes a tick.
  assign tick       = (presc_q == PRE_LAST);
  assign period_end = (pwm_cnt_q == PWM_LAST);

  always_comb begin
    presc_d       = presc_q;
    pwm_cnt_d     = pwm_cnt_q;
    frame_start_d = frame_start_q;
    fading_d      = fading_q;
    if (bus.ena) begin
      presc_d       = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d     = period_end ? '0 : pwm_cnt_q + 1'b1;
      frame_start_d = (pwm_cnt_d == '0);
      fading_d      = |fade_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      fading_q      <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_start_q <= frame_start_d;
      fading_q      <= fading_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .ena         (bus.ena),
      .tick        (tick),
      .period_end  (period_end),
      .pattern_bit (bus.pattern_in[i]),
      .pwm_cnt     (pwm_cnt_q),
      .led_o       (led_bits[i]),
      .fade_nxt_o  (fade_nxt[i])
    );
  end

  assign bus.led_out     = led_bits;
  assign bus.frame_start = frame_start_q;
  assign bus.fading      = fading_q;

endmodule

// File: tb/tb_led_fade_pwm_driver.sv
// Self-checking bench for led_fade_pwm_driver (default parameters).
// Gamma expectations switch with LED_FADE_GAMMA_EN.
module tb_led_fade_pwm_driver;
  import led_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_fade_pwm_driver_if #(.NUM_LEDS(8)) bus ();

  led_fade_pwm_driver #(
    .NUM_LEDS   (8),
    .PWM_BITS   (8),
    .DECAY_DIV  (16),
    .DECAY_STEP (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [7:0] lvl0 = dut.g_ch[0].u_ch.level_q;
  wire [7:0] lvl7 = dut.g_ch[7].u_ch.level_q;
  wire [7:0] pwm  = dut.pwm_cnt_q;

  int errors = 0;
  int checks = 0;
  int n      = 0;
  int lvl_sb[$];
  int duty_sb[$];

  function automatic int exp_duty(int l);
`ifdef LED_FADE_GAMMA_EN
    return (l == 255) ? 255 : (l * l) / 256;
`else
    return l;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1;
    bus.pattern_in = 8'h00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (bus.led_out !== 8'h00) begin errors++; $display("FAIL por_led_out: got %h expected 00", bus.led_out); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL por_frame_start: got %b expected 0", bus.frame_start); end
    checks++; if (bus.fading !== 1'b0) begin errors++; $display("FAIL por_fading: got %b expected 0", bus.fading); end
    checks++; if (pwm !== 8'd0) begin errors++; $display("FAIL por_pwm_cnt: got %0d expected 0", pwm); end
    bus.pattern_in = 8'hA5;
    repeat (100) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.led_out !== 8'h00) begin errors++; $display("FAIL mid_led_out: got %h expected 00", bus.led_out); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL mid_frame_start: got %b expected 0", bus.frame_start); end
    checks++; if (bus.fading !== 1'b0) begin errors++; $display("FAIL mid_fading: got %b expected 0", bus.fading); end
    checks++; if (pwm !== 8'd0) begin errors++; $display("FAIL mid_pwm_cnt: got %0d expected 0", pwm); end
    checks++; if (lvl0 !== 8'd0) begin errors++; $display("FAIL mid_level0: got %0d expected 0", lvl0); end
    checks++; if (lvl7 !== 8'd0) begin errors++; $display("FAIL mid_level7: got %0d expected 0", lvl7); end
  endtask

  task automatic test_steady_on();
    bus.ena = 1'b1;
    bus.pattern_in = 8'h01;
    do_reset();
    while (n < 800) begin
      step();
      checks++;
      if (bus.frame_start !== ((n % 255) == 0)) begin
        errors++; $display("FAIL steady_frame_start n=%0d: got %b expected %b", n, bus.frame_start, (n % 255) == 0);
      end
      if (n >= 256) begin
        checks++;
        if (bus.led_out !== 8'h01) begin errors++; $display("FAIL steady_led_out n=%0d: got %h expected 01", n, bus.led_out); end
      end
    end
  endtask

  task automatic test_decay();
    int drop;
    int lvl_m;
    int nxt;
    int prev_obs;
    int last_chg;
    int cnt;
    int exp;
    bit win;
    drop = 400;
    lvl_m = 0; last_chg = 0; cnt = 0; win = 1'b0;
    lvl_sb.delete();
    duty_sb.delete();
    bus.ena = 1'b1;
    bus.pattern_in = 8'h01;
    do_reset();
    while (n < 1100) begin
      bus.pattern_in = (n < drop) ? 8'h01 : 8'h00;
      if (n == drop) begin
        for (int k = 1; k <= 8; k++) lvl_sb.push_back((255 - 32 * k > 0) ? 255 - 32 * k : 0);
      end
      if ((n % 255) == 254) duty_sb.push_back(exp_duty(lvl_m));
      if (n < drop) nxt = 255;
      else if ((n % 16) == 15) nxt = (lvl_m > 32) ? lvl_m - 32 : 0;
      else nxt = lvl_m;
      prev_obs = int'(lvl0);
      step();
      lvl_m = nxt;
      if (n > drop && int'(lvl0) != prev_obs) begin
        checks++;
        if (lvl_sb.size() == 0) begin
          errors++; $display("FAIL decay_extra_step n=%0d: got level %0d expected no change", n, lvl0);
        end else begin
          exp = lvl_sb.pop_front();
          if (lvl0 !== 8'(exp)) begin errors++; $display("FAIL decay_level n=%0d: got %0d expected %0d", n, lvl0, exp); end
          checks++;
          if (bus.fading !== (exp != 0)) begin errors++; $display("FAIL decay_fading n=%0d: got %b expected %b", n, bus.fading, exp != 0); end
          if (last_chg > 0) begin
            checks++;
            if (n - last_chg != 16) begin errors++; $display("FAIL decay_interval n=%0d: got %0d expected 16", n, n - last_chg); end
          end
          last_chg = n;
        end
      end
      if ((n % 255) == 1 && duty_sb.size() > 0) begin win = 1'b1; cnt = 0; end
      if (win) cnt += int'(bus.led_out[0]);
      if (win && (n % 255) == 0) begin
        exp = duty_sb.pop_front();
        checks++;
        if (cnt != exp) begin errors++; $display("FAIL duty_high_cycles n=%0d: got %0d expected %0d", n, cnt, exp); end
        win = 1'b0;
      end
    end
    checks++; if (lvl_sb.size() != 0) begin errors++; $display("FAIL decay_missing_steps: got %0d left expected 0", lvl_sb.size()); end
    checks++; if (lvl0 !== 8'd0 || bus.fading !== 1'b0) begin errors++; $display("FAIL decay_final: got level %0d fading %b expected 0 0", lvl0, bus.fading); end
  endtask

  task automatic test_set_wins();
    bus.ena = 1'b1;
    bus.pattern_in = 8'h01;
    do_reset();
    step();
    bus.pattern_in = 8'h00;
    while (n < 15) step();
    checks++; if (lvl0 !== 8'd255) begin errors++; $display("FAIL setwin_pre: got %0d expected 255", lvl0); end
    bus.pattern_in = 8'h01;
    step();
    checks++; if (lvl0 !== 8'd255) begin errors++; $display("FAIL setwin_on_tick: got %0d expected 255", lvl0); end
    bus.pattern_in = 8'h00;
    while (n < 31) step();
    checks++; if (lvl0 !== 8'd255) begin errors++; $display("FAIL setwin_hold: got %0d expected 255", lvl0); end
    step();
    checks++; if (lvl0 !== 8'd223) begin errors++; $display("FAIL setwin_next_tick: got %0d expected 223", lvl0); end
  endtask

  task automatic test_freeze();
    bus.ena = 1'b1;
    bus.pattern_in = 8'h01;
    do_reset();
    while (n < 300) begin
      bus.pattern_in = (n < 255) ? 8'h01 : 8'h00;
      step();
    end
    checks++; if (lvl0 !== 8'd159 || pwm !== 8'd45) begin errors++; $display("FAIL freeze_entry: got level %0d pwm %0d expected 159 45", lvl0, pwm); end
    bus.ena = 1'b0;
    bus.pattern_in = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({pwm, lvl0, bus.led_out, bus.frame_start, bus.fading} !== {8'd45, 8'd159, 8'h01, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL freeze_hold c=%0d: got pwm %0d lvl %0d led %h fs %b fad %b expected 45 159 01 0 1",
                 c, pwm, lvl0, bus.led_out, bus.frame_start, bus.fading);
      end
    end
    bus.ena = 1'b1;
    bus.pattern_in = 8'h00;
    step();
    checks++; if (pwm !== 8'd46) begin errors++; $display("FAIL resume_pwm: got %0d expected 46", pwm); end
    step();
    step();
    checks++; if (lvl0 !== 8'd159) begin errors++; $display("FAIL resume_no_dup_tick: got %0d expected 159", lvl0); end
    step();
    checks++; if (lvl0 !== 8'd127) begin errors++; $display("FAIL resume_tick: got %0d expected 127", lvl0); end
  endtask

  task automatic test_gamma();
`ifdef LED_FADE_GAMMA_EN
    logic [15:0] g;
    g = led_gamma(16'd128, 8);
    checks++; if (g !== 16'd64) begin errors++; $display("FAIL gamma_128: got %0d expected 64", g); end
    g = led_gamma(16'd255, 8);
    checks++; if (g !== 16'd255) begin errors++; $display("FAIL gamma_255: got %0d expected 255", g); end
    g = led_gamma(16'd15, 8);
    checks++; if (g !== 16'd0) begin errors++; $display("FAIL gamma_15: got %0d expected 0", g); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.ena = 1'b0;
    bus.pattern_in = 8'h00;
    test_reset();
    test_steady_on();
    test_decay();
    test_set_wins();
    test_freeze();
    test_gamma();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
